kv_stream_reader: RTL and testbench

Sequencer that sits directly downstream of the KV cache. On `start` it walks a window of `seq_len` cache entries from `base_addr` (ring-buffer wrap modulo DEPTH) and drives the cache read port, absorbing its 1-cycle registered read latency. It delivers each {K,V} pair with its position index on a valid/ready stream to the attention datapath. Backpressure is honoured without losing or duplicating any entry.

---
 rtl/kv_pkg.sv | 27 ++
 rtl/kv_stream_reader_fifo.sv | 45 ++++
 rtl/kv_stream_reader.sv | 132 +++++++++++++
 tb/tb_kv_stream_reader.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_pkg.sv
// Shared types for the KV cache stream reader.
// Entry bundle, FSM states and address-width helper.
package kv_pkg;

  localparam int KV_DATA_W = 16;
  localparam int KV_DEPTH  = 256;

  function automatic int KV_ADDR_W(input int depth);
    return $clog2(depth);
  endfunction

  localparam int KV_AW = KV_ADDR_W(KV_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } kv_rd_state_e;

  typedef struct packed {
    logic [KV_DATA_W-1:0] k;
    logic [KV_DATA_W-1:0] v;
    logic [KV_AW:0]       pos;
    logic                 last;
  } kv_entry_t;

endpackage

// File: rtl/kv_stream_reader_fifo.sv
// Two-entry skid FIFO holding returned cache entries.
// Head is stable until popped; flush empties it synchronously.
module kv_skid_fifo
  import kv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  kv_entry_t  push_data,
  input  logic       pop,
  output kv_entry_t  head,
  output logic [1:0] count
);

  kv_entry_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/kv_stream_reader.sv
// Walks a ring-buffer window of the KV cache and streams
// {K,V,pos} entries on a valid/ready interface.
module kv_stream_reader
  import kv_pkg::*;
#(
  parameter  int DATA_WIDTH = KV_DATA_W,
  parameter  int DEPTH      = KV_DEPTH,
  localparam int ADDR_W     = KV_ADDR_W(DEPTH),
  localparam int LEN_W      = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      seq_len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] k_rd_data,
  input  logic [DATA_WIDTH-1:0] v_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_k,
  output logic [DATA_WIDTH-1:0] out_v,
  output logic [LEN_W-1:0]      out_pos,
  output logic                  out_last
);

  kv_rd_state_e      state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  start_len;
  logic              inflight;
  logic [LEN_W-1:0]  inflight_pos;
  logic              inflight_last;
  logic [1:0]        count;
  logic              pop;
  logic [2:0]        credit_use;
  logic              drained;
  kv_entry_t         head;
  kv_entry_t         push_entry;

  assign start_len  = (seq_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH)
                                                : seq_len;
  assign out_valid  = (count != 2'd0);
  assign pop        = out_valid & out_ready;
  // FIFO slots already claimed once this cycle's pop is retired
  assign credit_use = 3'(count) + 3'(inflight) - 3'(pop);
  assign drained    = (credit_use == 3'd0);

  assign busy    = (state != IDLE);
  assign rd_en   = (state == ISSUE) && (issued != len)
                && (credit_use < 3'd2);
  assign rd_addr = base + issued[ADDR_W-1:0];

  assign push_entry = '{
    k:    k_rd_data,
    v:    v_rd_data,
    pos:  inflight_pos,
    last: inflight_last
  };

  assign out_k    = head.k;
  assign out_v    = head.v;
  assign out_pos  = head.pos;
  assign out_last = out_valid & head.last;

  kv_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (inflight),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      base          <= '0;
      len           <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_pos  <= '0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= rd_en;
      inflight_pos  <= issued;
      inflight_last <= (issued == len - LEN_W'(1));
      if (abort) begin
        state    <= IDLE;
        inflight <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              base   <= base_addr;
              len    <= start_len;
              issued <= '0;
              if (start_len == '0) begin
                state <= DRAIN;
                done  <= 1'b1;
              end else begin
                state <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (rd_en) issued <= issued + LEN_W'(1);
            if (issued + LEN_W'(rd_en) == len) state <= DRAIN;
          end
          DRAIN: begin
            // zero-length runs enter here with done already high
            if (drained) begin
              state <= IDLE;
              done  <= ~done;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kv_stream_reader.sv
// Self-checking bench for kv_stream_reader with a cache model
// and a window-level reference of the expected stream.
module tb_kv_stream_reader;
  import kv_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   seq_len   = '0;
  logic          out_ready = 1'b1;
  logic          busy, done, rd_en, out_valid, out_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] k_rd_data, v_rd_data, out_k, out_v;
  logic [AW:0]   out_pos;

  logic [DW-1:0] k_mem [DEPTH];
  logic [DW-1:0] v_mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int ready_mode = 0;
  int stall_lo = 0;
  int stall_hi = -1;
  int r0, h0, d0, v0, s0;

  int            rd_cyc[$], rd_adr[$], hs_cyc[$], hs_pos[$], done_cyc[$];
  logic [DW-1:0] hs_k[$], hs_v[$];
  bit            hs_last[$];
  int            valid_seen = 0;
  int            stab_err = 0;
  logic          p_valid = 1'b0;
  logic          p_ready = 1'b0;
  logic [2*DW+AW+1:0] p_pay = '0;

  kv_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .seq_len   (seq_len),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .k_rd_data (k_rd_data),
    .v_rd_data (v_rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_k     (out_k),
    .out_v     (out_v),
    .out_pos   (out_pos),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd_en) begin
      k_rd_data <= k_mem[rd_addr];
      v_rd_data <= v_mem[rd_addr];
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1)
      out_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2)
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    else
      out_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        rd_cyc.push_back(cyc);
        rd_adr.push_back(int'(rd_addr));
      end
      if (out_valid) valid_seen = valid_seen + 1;
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        hs_k.push_back(out_k);
        hs_v.push_back(out_v);
        hs_pos.push_back(int'(out_pos));
        hs_last.push_back(out_last);
      end
      if (done) done_cyc.push_back(cyc);
      if (p_valid && !p_ready &&
          (!out_valid || {out_k, out_v, out_pos, out_last} != p_pay))
        stab_err = stab_err + 1;
      p_valid = out_valid;
      p_ready = out_ready;
      p_pay   = {out_k, out_v, out_pos, out_last};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, got hang expected finish");
    $fatal(1, "watchdog");
  end

  // Reference: entry i of a window is cache[(b+i) mod DEPTH]
  function automatic int stream_bad(input int h, input int b, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      int j = h + i;
      int a = (b + i) % DEPTH;
      if (j >= hs_k.size()) bad++;
      else if (hs_k[j] !== k_mem[a] || hs_v[j] !== v_mem[a] ||
               hs_pos[j] != i || hs_last[j] != (i == n - 1)) bad++;
    end
    return bad;
  endfunction

  task automatic mark();
    r0 = rd_adr.size();
    h0 = hs_k.size();
    d0 = done_cyc.size();
    v0 = valid_seen;
    s0 = stab_err;
  endtask

  task automatic launch(input int b, input int l);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(b);
    seq_len = (AW+1)'(l);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    #1 rst_n = 1'b0;
    #1;
    outs = {busy, done, rd_en, out_valid, out_last, rd_addr, out_k, out_v, out_pos};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    outs = {busy, done, rd_en, out_valid, out_last, rd_addr, out_k, out_v, out_pos};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_release_idle: got %h required 0", outs);
    end
  endtask

  task automatic test_basic();
    int bad = 0;
    mark();
    launch(0, 4);
    wait_idle("basic", 40);
    checks++;
    if (rd_adr.size() - r0 != 4) begin
      errors++;
      $display("FAIL basic_rd_count: got %0d required 4", rd_adr.size() - r0);
    end
    for (int i = 0; i < 4; i++) begin
      if (r0 + i >= rd_adr.size()) bad++;
      else if (rd_cyc[r0+i] - t0 != i + 1 || rd_adr[r0+i] != i) bad++;
      if (h0 + i >= hs_cyc.size()) bad++;
      else if (hs_cyc[h0+i] - t0 != i + 3) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_timing: got %0d bad rd/valid cycles required 0", bad);
    end
    bad = stream_bad(h0, 0, 4);
    checks++;
    if (bad != 0 || hs_k.size() - h0 != 4) begin
      errors++;
      $display("FAIL basic_stream: got %0d bad of %0d entries required 0 of 4", bad, hs_k.size() - h0);
    end
    checks++;
    if (done_cyc.size() - d0 != 1 || done_cyc[d0] - t0 != 7) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses first at rel %0d required 1 at 7",
               done_cyc.size() - d0, (done_cyc.size() > d0) ? done_cyc[d0] - t0 : -1);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    int exp_a[4] = '{254, 255, 0, 1};
    mark();
    launch(254, 4);
    wait_idle("wrap", 40);
    for (int i = 0; i < 4; i++)
      if (r0 + i >= rd_adr.size() || rd_adr[r0+i] != exp_a[i]) bad++;
    checks++;
    if (bad != 0 || rd_adr.size() - r0 != 4) begin
      errors++;
      $display("FAIL wrap_addr: got %0d bad of %0d reads required 0 of 4", bad, rd_adr.size() - r0);
    end
    bad = stream_bad(h0, 254, 4);
    checks++;
    if (bad != 0 || hs_k.size() - h0 != 4) begin
      errors++;
      $display("FAIL wrap_stream: got %0d bad required 0", bad);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    mark();
    stall_lo = 32'h7fff_ffff;
    stall_hi = 0;
    ready_mode = 2;
    launch(40, 8);
    stall_lo = t0 + 3;
    stall_hi = t0 + 10;
    at_cycle(t0 + 10);
    @(negedge clk);
    checks++;
    if (rd_adr.size() - r0 != 2) begin
      errors++;
      $display("FAIL bp_outstanding: got %0d reads during stall required 2", rd_adr.size() - r0);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pos !== '0) begin
      errors++;
      $display("FAIL bp_hold: got valid=%b pos=%0d required valid=1 pos=0", out_valid, out_pos);
    end
    wait_idle("bp", 80);
    ready_mode = 0;
    checks++;
    if (stab_err != s0) begin
      errors++;
      $display("FAIL bp_stable: got %0d payload changes required 0", stab_err - s0);
    end
    bad = stream_bad(h0, 40, 8);
    checks++;
    if (bad != 0 || hs_k.size() - h0 != 8 || done_cyc.size() - d0 != 1) begin
      errors++;
      $display("FAIL bp_stream: got %0d bad, %0d entries, %0d done required 0, 8, 1",
               bad, hs_k.size() - h0, done_cyc.size() - d0);
    end
  endtask

  task automatic test_random_ready();
    int bad;
    mark();
    ready_mode = 1;
    launch(17, 256);
    wait_idle("rand", 3000);
    ready_mode = 0;
    bad = stream_bad(h0, 17, 256);
    checks++;
    if (bad != 0 || hs_k.size() - h0 != 256) begin
      errors++;
      $display("FAIL rand_stream: got %0d bad, %0d entries required 0, 256", bad, hs_k.size() - h0);
    end
    checks++;
    if (rd_adr.size() - r0 != 256 || done_cyc.size() - d0 != 1) begin
      errors++;
      $display("FAIL rand_counts: got %0d reads %0d done required 256 reads 1 done",
               rd_adr.size() - r0, done_cyc.size() - d0);
    end
    checks++;
    if (stab_err != s0) begin
      errors++;
      $display("FAIL rand_stable: got %0d payload changes required 0", stab_err - s0);
    end
  endtask

  task automatic test_len0();
    mark();
    launch($urandom_range(0, 255), 0);
    wait_idle("len0", 20);
    checks++;
    if (rd_adr.size() != r0 || valid_seen != v0) begin
      errors++;
      $display("FAIL len0_activity: got %0d reads %0d valid cycles required 0 0",
               rd_adr.size() - r0, valid_seen - v0);
    end
    checks++;
    if (done_cyc.size() - d0 != 1 || done_cyc[d0] - t0 != 1) begin
      errors++;
      $display("FAIL len0_done: got %0d pulses first at rel %0d required 1 at 1",
               done_cyc.size() - d0, (done_cyc.size() > d0) ? done_cyc[d0] - t0 : -1);
    end
  endtask

  task automatic test_clamp();
    int b = $urandom_range(0, 255);
    int bad;
    mark();
    launch(b, 300);
    wait_idle("clamp", 1000);
    bad = stream_bad(h0, b, 256);
    checks++;
    if (bad != 0 || hs_k.size() - h0 != 256 || rd_adr.size() - r0 != 256) begin
      errors++;
      $display("FAIL clamp_stream: got %0d bad, %0d entries, %0d reads required 0, 256, 256",
               bad, hs_k.size() - h0, rd_adr.size() - r0);
    end
  endtask

  task automatic test_busy_start();
    int b = $urandom_range(0, 255);
    int bad;
    mark();
    launch(b, 6);
    at_cycle(t0 + 2);
    start = 1'b1;
    base_addr = AW'(b ^ 8'h55);
    seq_len = 9'd3;
    at_cycle(t0 + 3);
    start = 1'b0;
    at_cycle(t0 + 4);
    start = 1'b1;
    at_cycle(t0 + 5);
    start = 1'b0;
    wait_idle("busy_start", 40);
    bad = stream_bad(h0, b, 6);
    checks++;
    if (bad != 0 || hs_k.size() - h0 != 6 || done_cyc.size() - d0 != 1) begin
      errors++;
      $display("FAIL busy_start: got %0d bad, %0d entries, %0d done required 0, 6, 1",
               bad, hs_k.size() - h0, done_cyc.size() - d0);
    end
  endtask

  task automatic test_abort();
    int b2 = $urandom_range(0, 255);
    int bad;
    mark();
    launch($urandom_range(0, 255), 16);
    at_cycle(t0 + 5);
    abort = 1'b1;
    at_cycle(t0 + 6);
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_flush: got busy=%b valid=%b required 0 0", busy, out_valid);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cyc.size() != d0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses required 0", done_cyc.size() - d0);
    end
    mark();
    launch(b2, 5);
    wait_idle("after_abort", 40);
    bad = stream_bad(h0, b2, 5);
    checks++;
    if (bad != 0 || hs_k.size() - h0 != 5 || done_cyc.size() - d0 != 1) begin
      errors++;
      $display("FAIL abort_restart: got %0d bad, %0d entries, %0d done required 0, 5, 1",
               bad, hs_k.size() - h0, done_cyc.size() - d0);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] outs;
    launch($urandom_range(0, 255), 16);
    at_cycle(t0 + 4);
    #2 rst_n = 1'b0;
    #1;
    outs = {busy, done, rd_en, out_valid, out_last, rd_addr, out_k, out_v, out_pos};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", outs);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_idle: got busy=%b valid=%b required 0 0", busy, out_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      k_mem[i] = DW'($urandom);
      v_mem[i] = DW'($urandom);
    end
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_random_ready();
    test_len0();
    test_clamp();
    test_busy_start();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
